// File: rtl/div_share_ctrl.sv
// div_share_ctrl: two-requester round-robin front end sharing one iterative
// restoring divider (one quotient bit per cycle, MSB first). Results leave on
// a valid/ready channel. A zero divisor gives quotient 0, remainder = dividend.
module div_share_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_dividend,
  input  logic [WIDTH-1:0] req0_divisor,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_dividend,
  input  logic [WIDTH-1:0] req1_divisor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic             rsp_dbz,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_dbz_q, rsp_dbz_d;
  logic [WIDTH-1:0] rsp_quotient_q, rsp_quotient_d;
  logic [WIDTH-1:0] rsp_remainder_q, rsp_remainder_d;

  logic             grant0, grant1;
  logic [WIDTH:0]   trial;
  logic             trial_ge;
  logic [WIDTH-1:0] rem_next, quo_next;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant0 = req0_valid;
    grant1 = req1_valid;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant_q;
      grant1 = !last_grant_q;
    end
  end

  assign req0_ready = (state_q == IDLE) && grant0 && !rst;
  assign req1_ready = (state_q == IDLE) && grant1 && !rst;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial    = {rem_q, dividend_q[WIDTH-1]};
    trial_ge = (trial >= {1'b0, divisor_q});
    rem_next = trial_ge ? (trial[WIDTH-1:0] - divisor_q) : trial[WIDTH-1:0];
    quo_next = (quo_q << 1) | WIDTH'(trial_ge);
  end

  // Next-state and next-output logic for the IDLE/CALC/RESP controller.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    id_d            = id_q;
    zero_d          = zero_q;
    dividend_d      = dividend_q;
    divisor_d       = divisor_q;
    rem_d           = rem_q;
    quo_d           = quo_q;
    cnt_d           = cnt_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_id_d        = rsp_id_q;
    rsp_dbz_d       = rsp_dbz_q;
    rsp_quotient_d  = rsp_quotient_q;
    rsp_remainder_d = rsp_remainder_q;

    case (state_q)
      IDLE: begin
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          id_d         = req1_ready;
          last_grant_d = req1_ready;
          dividend_d   = req1_ready ? req1_dividend : req0_dividend;
          divisor_d    = req1_ready ? req1_divisor : req0_divisor;
          zero_d       = ((req1_ready ? req1_divisor : req0_divisor) == '0);
          rem_d        = '0;
          quo_d        = '0;
          cnt_d        = '0;
          state_d      = CALC;
        end
      end

      CALC: begin
        if (zero_q) begin
          // Zero divisor spends a single cycle here and skips the iterations.
          state_d         = RESP;
          rsp_valid_d     = 1'b1;
          rsp_id_d        = id_q;
          rsp_dbz_d       = 1'b1;
          rsp_quotient_d  = '0;
          rsp_remainder_d = dividend_q;
        end else begin
          rem_d      = rem_next;
          quo_d      = quo_next;
          dividend_d = dividend_q << 1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_d         = RESP;
            rsp_valid_d     = 1'b1;
            rsp_id_d        = id_q;
            rsp_dbz_d       = 1'b0;
            rsp_quotient_d  = quo_next;
            rsp_remainder_d = rem_next;
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; discards any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= 1'b0;
      rsp_dbz_q       <= 1'b0;
      rsp_quotient_q  <= '0;
      rsp_remainder_q <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_id_q        <= rsp_id_d;
      rsp_dbz_q       <= rsp_dbz_d;
      rsp_quotient_q  <= rsp_quotient_d;
      rsp_remainder_q <= rsp_remainder_d;
    end
  end

  // Datapath registers: always loaded at accept before they are used.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are not reset; the accept path initialises them.
    id_q       <= id_d;
    zero_q     <= zero_d;
    dividend_q <= dividend_d;
    divisor_q  <= divisor_d;
    rem_q      <= rem_d;
    quo_q      <= quo_d;
    cnt_q      <= cnt_d;
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_quotient  = rsp_quotient_q;
  assign rsp_remainder = rsp_remainder_q;
  assign rsp_dbz       = rsp_dbz_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: a transaction-level model (pending result plus a
// countdown) is compared against every output on every falling edge, and
// directed scenarios check hand-computed literals.
module tb_div_share_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_dividend, req0_divisor;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_dividend, req1_divisor;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_dbz, busy;
  logic [WIDTH-1:0] rsp_quotient, rsp_remainder;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  div_share_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 = free, 1 = working (countdown to result), 2 = result waiting
  int       m_phase = 0;
  int       m_cnt   = 0;
  bit       m_lastg = 1'b1;
  bit       m_valid = 1'b0, m_id = 1'b0, m_dbz = 1'b0;
  bit [3:0] m_q = '0, m_r = '0;
  bit       p_id, p_dbz;
  bit [3:0] p_q, p_r;

  function automatic bit exp_rdy0();
    return (m_phase == 0) && !rst && req0_valid && (!req1_valid || m_lastg);
  endfunction

  function automatic bit exp_rdy1();
    return (m_phase == 0) && !rst && req1_valid && (!req0_valid || !m_lastg);
  endfunction

  task automatic m_accept(input bit id, input bit [3:0] a, input bit [3:0] b);
    m_lastg = id;
    p_id    = id;
    p_dbz   = (b == 0);
    p_q     = (b == 0) ? 4'd0 : 4'(a / b);
    p_r     = (b == 0) ? a : 4'(a % b);
    m_cnt   = (b == 0) ? 1 : WIDTH;
    m_phase = 1;
  endtask

  always @(posedge clk) begin
    bit g0, g1;
    g0 = exp_rdy0();
    g1 = exp_rdy1();
    if (rst) begin
      m_phase = 0; m_lastg = 1'b1; m_valid = 1'b0;
      m_id = 1'b0; m_dbz = 1'b0; m_q = '0; m_r = '0;
    end else begin
      case (m_phase)
        0: begin
          if (g0) m_accept(1'b0, req0_dividend, req0_divisor);
          else if (g1) m_accept(1'b1, req1_dividend, req1_divisor);
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_phase = 2; m_valid = 1'b1;
            m_id = p_id; m_dbz = p_dbz; m_q = p_q; m_r = p_r;
          end
        end
        default: begin
          if (rsp_ready) begin
            m_phase = 0; m_valid = 1'b0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_req0_ready", req0_ready, exp_rdy0());
      check("cmp_req1_ready", req1_ready, exp_rdy1());
      check("cmp_busy", busy, m_phase != 0);
      check("cmp_rsp_valid", rsp_valid, m_valid);
      check("cmp_rsp_id", rsp_id, m_id);
      check("cmp_rsp_quotient", rsp_quotient, m_q);
      check("cmp_rsp_remainder", rsp_remainder, m_r);
      check("cmp_rsp_dbz", rsp_dbz, m_dbz);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted; returns the cycles waited.
  task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b, output int waits);
    bit got = 1'b0;
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_dividend = a; req0_divisor = b;
    end else begin
      req1_valid = 1'b1; req1_dividend = a; req1_divisor = b;
    end
    waits = 0;
    while (!got && waits < 64) begin
      @(negedge clk);
      waits++;
      if ((id == 1'b0) ? req0_ready : req1_ready) got = 1'b1;
      step();
    end
    if (id == 1'b0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
    check("accept_seen", got, 1'b1);
  endtask

  // Wait (bounded) for rsp_valid; returns at the falling edge where it is seen.
  task automatic wait_rsp(output int n);
    bit got = 1'b0;
    n = 0;
    while (!got && n < 64) begin
      @(negedge clk);
      n++;
      if (rsp_valid) got = 1'b1;
    end
    check("rsp_seen", got, 1'b1);
  endtask

  task automatic check_rsp(input string tag, input bit id, input logic [3:0] q,
                           input logic [3:0] r, input bit dbz);
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_q"}, rsp_quotient, q);
    check({tag, "_r"}, rsp_remainder, r);
    check({tag, "_dbz"}, rsp_dbz, dbz);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    bit exp_ids [4];
    logic [3:0] exp_q [4];
    logic [3:0] exp_r [4];
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_q   = '{4'd3, 4'd1, 4'd3, 4'd1};
    exp_r   = '{4'd3, 4'd0, 4'd3, 4'd0};

    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_dividend = '0; req0_divisor = '0;
    req1_valid = 1'b0; req1_dividend = '0; req1_divisor = '0;
    step();
    chk_en = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    step();
    // Reset state, with requests present to confirm ready is forced low.
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_q", rsp_quotient, 4'd0);
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Single request: 13/3 accepted the cycle it appears, result 4 edges later.
    rst = 1'b0;
    issue(1'b0, 4'd13, 4'd3, w);
    check("t1_accept_wait", w, 1);
    wait_rsp(n);
    check("t1_latency", n - 1, 4);
    check_rsp("t1", 1'b0, 4'd4, 4'd1, 1'b0);
    step();

    // Divide by zero on req1: 9/0 -> q=0, r=9, one edge after accept.
    issue(1'b1, 4'd9, 4'd0, w);
    wait_rsp(n);
    check("t2_latency", n - 1, 1);
    check_rsp("t2", 1'b1, 4'd0, 4'd9, 1'b1);
    step();

    // Contention from reset: grants alternate 0,1,0,1.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    req0_valid = 1'b1; req0_dividend = 4'd15; req0_divisor = 4'd4;
    req1_valid = 1'b1; req1_dividend = 4'd7;  req1_divisor = 4'd7;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(n);
      check_rsp($sformatf("t3_%0d", k), exp_ids[k], exp_q[k], exp_r[k], 1'b0);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure: 14/5 held for several cycles, readys stay low meanwhile.
    rsp_ready = 1'b0;
    issue(1'b0, 4'd14, 4'd5, w);
    wait_rsp(n);
    step();
    req1_valid = 1'b1; req1_dividend = 4'd2; req1_divisor = 4'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t4_hold_valid", rsp_valid, 1'b1);
      check_rsp("t4_hold", 1'b0, 4'd2, 4'd4, 1'b0);
      check("t4_hold_ready1", req1_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    check("t4_idle_valid", rsp_valid, 1'b0);
    check("t4_fresh_ready1", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    wait_rsp(n);
    check_rsp("t4_next", 1'b1, 4'd2, 4'd0, 1'b0);
    step();

    // Reset two edges after accepting 11/2: the operation is dropped.
    issue(1'b0, 4'd11, 4'd2, w);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_rsp", rsp_valid, 1'b0);
      step();
    end
    req0_valid = 1'b1; req0_dividend = 4'd11; req0_divisor = 4'd2;
    req1_valid = 1'b1; req1_dividend = 4'd3;  req1_divisor = 4'd1;
    wait_rsp(n);
    check_rsp("t5_first", 1'b0, 4'd5, 4'd1, 1'b0);
    step();
    req0_valid = 1'b0;
    wait_rsp(n);
    check_rsp("t5_second", 1'b1, 4'd3, 4'd0, 1'b0);
    step();
    req1_valid = 1'b0;

    // Exhaustive sweep on each requester against integer division.
    for (int id = 0; id < 2; id++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          issue(id[0], a[3:0], b[3:0], w);
          wait_rsp(n);
          check_rsp("ex", id[0], (b == 0) ? 4'd0 : 4'(a / b),
                    (b == 0) ? a[3:0] : 4'(a % b), b == 0);
          step();
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
